// File: rtl/uwire_pkg.sv
// Shared types and widths for the LMK04816 uWire arbiter slice.
package uwire_pkg;

    localparam int UWIRE_WORD_W = 32;
    localparam int UWIRE_ADDR_W = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        GAP       = 3'd4
    } state_e;

    typedef enum logic {
        REQ_BOOT = 1'b0,
        REQ_HOST = 1'b1
    } req_e;

endpackage

// File: rtl/uwire_shadow_regs.sv
// 32-entry shadow of the last word issued to each LMK register address.
// Only instantiated when UWIRE_ARB_SHADOW_EN is defined.
module uwire_shadow_regs
    import uwire_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [UWIRE_ADDR_W-1:0] waddr,
    input  logic [UWIRE_WORD_W-1:0] wdata,
    input  logic [UWIRE_ADDR_W-1:0] raddr,
    output logic [UWIRE_WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << UWIRE_ADDR_W;

    logic [UWIRE_WORD_W-1:0] mem_reg [DEPTH];
    logic [DEPTH-1:0]        hit;

    // Per-entry write decode keeps the storage loop below trivially simple.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
        assign hit[gi] = we && (waddr == UWIRE_ADDR_W'(gi));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (hit[i]) begin
                    mem_reg[i] <= wdata;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem_reg[raddr];
        end
    end

endmodule

// File: rtl/uwire_arbiter.sv
// Boot/host arbiter in front of one uWire serializer with inter-word gap and watchdog.
// Optional shadow register file enabled by defining UWIRE_ARB_SHADOW_EN.
module uwire_arbiter
    import uwire_pkg::*;
#(
    parameter int MIN_GAP        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    boot_valid,
    input  logic [UWIRE_WORD_W-1:0] boot_d,
    output logic                    boot_ready,
    input  logic                    boot_done,
    input  logic                    host_valid,
    input  logic [UWIRE_WORD_W-1:0] host_d,
    output logic                    host_ready,
    output logic                    ser_start,
    output logic [UWIRE_WORD_W-1:0] ser_d,
    input  logic                    ser_ready,
    output logic                    grant,
    output logic                    busy,
    output logic                    timeout,
    output logic [31:0]             wr_count,
    input  logic [UWIRE_ADDR_W-1:0] shadow_addr,
    output logic [UWIRE_WORD_W-1:0] shadow_q
);

    localparam logic [31:0] WDOG_LAST = 32'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST  = 8'(MIN_GAP - 1);

    state_e                  state_reg, state_next;
    logic [31:0]             wdog_reg, wdog_next;
    logic [7:0]              gap_reg, gap_next;
    logic [UWIRE_WORD_W-1:0] ser_d_reg, ser_d_next;
    req_e                    grant_reg, grant_next;
    logic                    timeout_reg, timeout_next;
    logic [31:0]             wr_count_reg, wr_count_next;
    logic                    boot_done_seen_reg, boot_done_seen_next;

    logic boot_acc;
    logic host_acc;
    logic wdog_expired;

    assign boot_acc     = (state_reg == IDLE) && boot_valid;
    assign host_acc     = (state_reg == IDLE) && host_valid && !boot_valid && boot_done_seen_reg;
    assign wdog_expired = (wdog_reg == WDOG_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= IDLE;
            wdog_reg           <= '0;
            gap_reg            <= '0;
            ser_d_reg          <= '0;
            grant_reg          <= REQ_BOOT;
            timeout_reg        <= 1'b0;
            wr_count_reg       <= '0;
            boot_done_seen_reg <= 1'b0;
        end else begin
            state_reg          <= state_next;
            wdog_reg           <= wdog_next;
            gap_reg            <= gap_next;
            ser_d_reg          <= ser_d_next;
            grant_reg          <= grant_next;
            timeout_reg        <= timeout_next;
            wr_count_reg       <= wr_count_next;
            boot_done_seen_reg <= boot_done_seen_next;
        end
    end

    always_comb begin
        state_next          = state_reg;
        wdog_next           = wdog_reg;
        gap_next            = gap_reg;
        ser_d_next          = ser_d_reg;
        grant_next          = grant_reg;
        timeout_next        = timeout_reg;
        wr_count_next       = wr_count_reg;
        boot_done_seen_next = boot_done_seen_reg | boot_done;

        case (state_reg)
            IDLE: begin
                if (boot_acc) begin
                    state_next = ISSUE;
                    ser_d_next = boot_d;
                    grant_next = REQ_BOOT;
                    wdog_next  = '0;
                end else if (host_acc) begin
                    state_next = ISSUE;
                    ser_d_next = host_d;
                    grant_next = REQ_HOST;
                    wdog_next  = '0;
                end
            end
            ISSUE: begin
                state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (wdog_expired) begin
                    timeout_next = 1'b1;
                    state_next   = GAP;
                    gap_next     = '0;
                end else begin
                    wdog_next = wdog_reg + 32'd1;
                    if (!ser_ready) begin
                        state_next = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                // A completing word wins over a watchdog expiry in the same cycle.
                if (ser_ready) begin
                    state_next    = GAP;
                    gap_next      = '0;
                    wr_count_next = wr_count_reg + 32'd1;
                end else if (wdog_expired) begin
                    timeout_next = 1'b1;
                    state_next   = GAP;
                    gap_next     = '0;
                end else begin
                    wdog_next = wdog_reg + 32'd1;
                end
            end
            GAP: begin
                if (gap_reg == GAP_LAST) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_reg + 8'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Ready outputs are gated by rst so they read 0 for the whole reset pulse.
    assign boot_ready = boot_acc && !rst;
    assign host_ready = host_acc && !rst;
    assign ser_start  = (state_reg == ISSUE);
    assign busy       = (state_reg != IDLE);
    assign ser_d      = ser_d_reg;
    assign grant      = grant_reg;
    assign timeout    = timeout_reg;
    assign wr_count   = wr_count_reg;

`ifdef UWIRE_ARB_SHADOW_EN
    uwire_shadow_regs u_shadow (
        .clk   (clk),
        .rst   (rst),
        .we    (state_reg == ISSUE),
        .waddr (ser_d_reg[UWIRE_ADDR_W-1:0]),
        .wdata (ser_d_reg),
        .raddr (shadow_addr),
        .rdata (shadow_q)
    );
`else
    logic unused_shadow_addr;
    assign unused_shadow_addr = ^shadow_addr;
    assign shadow_q           = '0;
`endif

endmodule

// File: tb/tb_uwire_arbiter.sv
// Directed bench for uwire_arbiter: scoreboard of issued words checked at each ser_start.
module tb_uwire_arbiter;

    localparam int MIN_GAP = 4;
    localparam int TMO     = 100;
    localparam int BOUND   = 3000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        boot_valid = 1'b0;
    logic [31:0] boot_d = '0;
    logic        boot_ready;
    logic        boot_done = 1'b0;
    logic        host_valid = 1'b0;
    logic [31:0] host_d = '0;
    logic        host_ready;
    logic        ser_start;
    logic [31:0] ser_d;
    logic        ser_ready;
    logic        grant;
    logic        busy;
    logic        timeout;
    logic [31:0] wr_count;
    logic [4:0]  shadow_addr = '0;
    logic [31:0] shadow_q;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;
    int last_done = -1000;
    int last_start = -1000;
    logic [31:0] prev_wr = '0;
    logic [32:0] sb_q[$];
    logic        ser_stuck = 1'b0;
    int          ser_cnt;

    uwire_arbiter #(.MIN_GAP(MIN_GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .boot_valid  (boot_valid),
        .boot_d      (boot_d),
        .boot_ready  (boot_ready),
        .boot_done   (boot_done),
        .host_valid  (host_valid),
        .host_d      (host_d),
        .host_ready  (host_ready),
        .ser_start   (ser_start),
        .ser_d       (ser_d),
        .ser_ready   (ser_ready),
        .grant       (grant),
        .busy        (busy),
        .timeout     (timeout),
        .wr_count    (wr_count),
        .shadow_addr (shadow_addr),
        .shadow_q    (shadow_q)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serializer model: ready drops the cycle after start and stays low 40 cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ser_ready <= 1'b1;
            ser_cnt   <= 0;
        end else if (ser_start && !ser_stuck) begin
            ser_ready <= 1'b0;
            ser_cnt   <= 40;
        end else if (ser_cnt > 1) begin
            ser_cnt <= ser_cnt - 1;
        end else if (ser_cnt == 1) begin
            ser_cnt   <= 0;
            ser_ready <= 1'b1;
        end
    end

    // Output monitor: gap rule, scoreboard pop on each start pulse.
    always @(negedge clk) begin
        if (rst) begin
            prev_wr   = '0;
            last_done = -1000;
        end else begin
            if (wr_count !== prev_wr) last_done = cyc;
            prev_wr = wr_count;
            if (ser_start) begin
                logic [32:0] e;
                n_start++;
                last_start = cyc;
                check("start_gap", 32'((cyc - last_done) >= (MIN_GAP + 1)), 32'd1);
                check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    check("ser_d", ser_d, e[31:0]);
                    check("grant", 32'(grant), 32'(e[32]));
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input bit host, input logic [31:0] w);
        int k = 0;
        if (host) begin host_valid = 1'b1; host_d = w; end
        else      begin boot_valid = 1'b1; boot_d = w; end
        #1;
        while (!(host ? host_ready : boot_ready) && k < BOUND) begin
            @(negedge clk); #1; k++;
        end
        check(host ? "host_accept_wait" : "boot_accept_wait", 32'(k < BOUND), 32'd1);
        sb_q.push_back({host, w});
        @(posedge clk); #1;
        if (host) host_valid = 1'b0; else boot_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < BOUND) begin @(negedge clk); k++; end
        check("idle_wait", 32'(k < BOUND), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_boot_ready"}, 32'(boot_ready), 32'd0);
        check({tag, "_host_ready"}, 32'(host_ready), 32'd0);
        check({tag, "_ser_start"},  32'(ser_start),  32'd0);
        check({tag, "_ser_d"},      ser_d,           32'd0);
        check({tag, "_grant"},      32'(grant),      32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_timeout"},    32'(timeout),    32'd0);
        check({tag, "_wr_count"},   wr_count,        32'd0);
        check({tag, "_shadow_q"},   shadow_q,        32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        int n0;
        int k;
        // Reset with valids high: ready outputs must still read 0.
        #2 rst = 1'b1;
        boot_valid = 1'b1;
        host_valid = 1'b1;
        #1 check_reset_outputs("reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0; boot_valid = 1'b0; host_valid = 1'b0;
        @(negedge clk);

        // Boot only
        send(1'b0, 32'h00140140);
        send(1'b0, 32'h00140281);
        send(1'b0, 32'h1000000E);
        wait_idle();
        check("boot_wr_count", wr_count, 32'd3);
        check("boot_starts", 32'(n_start), 32'd3);

        // Host locked out until boot_done
        n0 = n_start;
        host_valid = 1'b1; host_d = 32'h0B8C01AC;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            check("host_locked", 32'(host_ready), 32'd0);
        end
        check("host_locked_starts", 32'(n_start), 32'(n0));
        boot_done = 1'b1;
        @(negedge clk);
        boot_done = 1'b0;
        send(1'b1, 32'h0B8C01AC);
        wait_idle();
        check("host_grant", 32'(grant), 32'd1);
        check("host_wr_count", wr_count, 32'd4);

        // Contention: boot wins, host follows
        boot_valid = 1'b1; boot_d = 32'h00000025;
        host_valid = 1'b1; host_d = 32'h00000126;
        #1;
        check("cont_boot_ready", 32'(boot_ready), 32'd1);
        check("cont_host_ready", 32'(host_ready), 32'd0);
        sb_q.push_back({1'b0, 32'h00000025});
        @(posedge clk); #1 boot_valid = 1'b0;
        @(negedge clk);
        send(1'b1, 32'h00000126);
        wait_idle();
        check("cont_wr_count", wr_count, 32'd6);
        check("cont_grant", 32'(grant), 32'd1);
        check("cont_sb_drained", 32'(sb_q.size()), 32'd0);

        // Watchdog: serializer never drops ready
        ser_stuck = 1'b1;
        send(1'b0, 32'h00000003);
        check("wd_timeout_early", 32'(timeout), 32'd0);
        k = 0;
        while (!timeout && k < 500) begin @(negedge clk); k++; end
        check("wd_timeout_set", 32'(timeout), 32'd1);
        check("wd_timeout_latency", 32'(((cyc - last_start) >= TMO) && ((cyc - last_start) <= TMO + 2)), 32'd1);
        wait_idle();
        check("wd_wr_count", wr_count, 32'd6);
        ser_stuck = 1'b0;
        send(1'b0, 32'h00000004);
        wait_idle();
        check("wd_next_wr_count", wr_count, 32'd7);
        check("wd_sticky", 32'(timeout), 32'd1);

        // Reset in WAIT_DONE with a host word in flight
        n0 = n_start;
        send(1'b1, 32'h0B8C01AD);
        repeat (10) @(negedge clk);
        check("rst_mid_busy_before", 32'(busy), 32'd1);
        boot_valid = 1'b1; host_valid = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0; boot_valid = 1'b0;
        n0 = n_start;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_done_seen_cleared", 32'(host_ready), 32'd0);
        end
        check("rst_no_start", 32'(n_start), 32'(n0));
        host_valid = 1'b0;
        @(negedge clk);

`ifdef UWIRE_ARB_SHADOW_EN
        send(1'b0, 32'h8000800F);
        wait_idle();
        shadow_addr = 5'd15;
        @(negedge clk);
        check("shadow_15", shadow_q, 32'h8000800F);
        shadow_addr = 5'd14;
        @(negedge clk);
        check("shadow_14", shadow_q, 32'd0);
`else
        send(1'b0, 32'h8000800F);
        wait_idle();
        shadow_addr = 5'd15;
        @(negedge clk);
        check("shadow_off", shadow_q, 32'd0);
`endif
        check("final_sb_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uwire_arbiter.md
# uwire_arbiter

Shares one LMK04816 uWire serializer (start/d/ready handshake) between the boot-time configuration loader and a runtime host (SoC register) requester. The boot requester has strict priority; the host is locked out until the loader reports completion. The block sits in the clock subsystem between the loader, the host register interface and the serializer, all on the oscillator clock domain. It enforces a minimum inter-word gap and a serializer watchdog, and counts completed writes.

## Interface
- MIN_GAP, 4: idle cycles enforced between a completed word and the next ser_start (1..255).
- TIMEOUT_CYCLES, 1000000: maximum cycles spent waiting on the serializer per word.
- clk  in  1  oscillator-domain clock.
- rst  in  1  reset, asynchronous, active-high.
- boot_valid  in  1  loader has a word.
- boot_d  in  32  loader word; bits [4:0] are the LMK register address.
- boot_ready  out  1  word accepted when boot_valid & boot_ready.
- boot_done  in  1  loader finished; sampled into a sticky flag.
- host_valid  in  1  host has a word.
- host_d  in  32  host word.
- host_ready  out  1  word accepted when host_valid & host_ready.
- ser_start  out  1  one-cycle start pulse to the serializer.
- ser_d  out  32  word to serialize; held stable from ser_start until the word completes.
- ser_ready  in  1  serializer idle (level).
- grant  out  1  owner of the current or last word: 0 = boot, 1 = host.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; set on a watchdog expiry.
- wr_count  out  32  completed words; wraps.
- shadow_addr  in  5  shadow read address (macro only).
- shadow_q  out  32  shadow read data (macro only).

## Operation
- States:
  - IDLE → ISSUE on accept.
  - ISSUE (ser_start=1) → WAIT_ACK.
  - WAIT_ACK: ser_ready low → WAIT_DONE.
  - WAIT_DONE: ser_ready high → GAP; wr_count+1.
  - GAP: counts MIN_GAP cycles → IDLE.
- Watchdog counter clears on entry to ISSUE and increments in WAIT_ACK and WAIT_DONE. When it reaches TIMEOUT_CYCLES: set timeout, go to GAP, do not increment wr_count, discard the word.
- boot_ready = (state==IDLE) & boot_valid.
- host_ready = (state==IDLE) & host_valid & ~boot_valid & boot_done_seen.
- Simultaneous valid: boot wins, and the host waits.
- Both ready outputs are combinational from registered state and the valid inputs.
- boot_done_seen sets on boot_done high and clears only on rst. Host words issued before it is set stall with no error.
- A boot word is still accepted after boot_done_seen is set.
- On accept: ser_d ← the accepted word; grant ← requester.
- timeout clears only on rst.

## Timing
- Word accepted at cycle N: ser_start high in cycle N+1 only; busy high from N+1.
- Earliest next accept is MIN_GAP+1 cycles after the WAIT_DONE exit edge. Throughput is bounded by the serializer plus MIN_GAP.
- wr_count updates on the cycle leaving WAIT_DONE.
- shadow_q has 1-cycle registered read latency.
- Reset (async, including mid-word): state=IDLE and every output 0 immediately (boot_ready, host_ready, ser_start, ser_d, grant, busy, timeout, wr_count, shadow_q). boot_done_seen, watchdog and gap counters are also zeroed. The word in flight is lost.
- wr_count wraps from 0xFFFFFFFF to 0.

## Configuration
- UWIRE_ARB_SHADOW_EN defined: a 32×32 shadow register file.
  - The entry at ser_d[4:0] is written with ser_d in the ISSUE cycle, whether or not the word later times out.
  - Reset clears all entries to 0.
  - shadow_q = shadow[shadow_addr], registered.
- UWIRE_ARB_SHADOW_EN undefined: no storage; shadow_q tied 0; shadow_addr ignored.

## Structure
- Package uwire_pkg holds:
  - UWIRE_WORD_W=32 and UWIRE_ADDR_W=5.
  - The state enum (IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP).
  - The requester enum (REQ_BOOT=0, REQ_HOST=1).
- Sub-module uwire_shadow_regs holds the shadow file, instantiated only under the macro.

## Test plan
- Boot only: 3 words 0x00140140, 0x00140281, 0x1000000E. Serializer model drops ready 1 cycle after start and holds it low 40 cycles. Expect 3 ser_start pulses, each ≥ MIN_GAP+1 cycles after the previous completion, and wr_count=3.
- Host before boot_done: host_valid with 0x0B8C01AC while boot_done=0. Expect host_ready=0 indefinitely and no ser_start. After a boot_done pulse, the word is issued and grant=1.
- Contention: boot_valid and host_valid asserted in the same cycle with boot_done_seen set. Expect the boot word first (grant=0), then the host word, with no words lost.
- Watchdog: TIMEOUT_CYCLES=100 and ser_ready stuck high after start. Expect timeout=1 at cycle 100 of WAIT_ACK, wr_count unchanged, and the next word still accepted.
- Reset mid-word: assert rst during WAIT_DONE. Expect all outputs 0 asynchronously, state IDLE, boot_done_seen cleared.
- Shadow (macro on): write 0x8000800F, read shadow_addr=15 → 0x8000800F one cycle later; shadow_addr=14 reads 0.
